// File: rtl/mesi_line_array.sv
// mesi_line_array: MESI state store and next-state engine for NUM_LINES lines.
// Takes one processor or snooped bus operation per cycle and registers the
// old/new line state, the bus operation to issue and the snoop reply.
// CLEAR sweeps every line back to I, one line per cycle.
// Optional feature macro: MESI_STATS_EN enables the saturating hit/miss
// counters; when it is undefined, hit_cnt/miss_cnt are tied to zero.
module mesi_line_array #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES),
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [IDX_W-1:0] op_idx,
  input  logic [1:0]       snoop_in,
  output logic             rsp_valid,
  output logic [1:0]       rsp_old,
  output logic [1:0]       rsp_new,
  output logic [2:0]       bus_op,
  output logic [1:0]       snoop_out,
  output logic             proto_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [2:0] OP_PR_RD   = 3'd0;
  localparam logic [2:0] OP_PR_WR   = 3'd1;
  localparam logic [2:0] OP_SN_RD   = 3'd2;
  localparam logic [2:0] OP_SN_WR   = 3'd3;
  localparam logic [2:0] OP_SN_RWIM = 3'd4;
  localparam logic [2:0] OP_SN_INV  = 3'd5;
  localparam logic [2:0] OP_CLEAR   = 3'd6;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [2:0] BUS_NONE  = 3'd0;
  localparam logic [2:0] BUS_READ  = 3'd1;
  localparam logic [2:0] BUS_WRITE = 3'd2;
  localparam logic [2:0] BUS_INV   = 3'd3;
  localparam logic [2:0] BUS_RWIM  = 3'd4;

  localparam logic [1:0] SNP_HIT   = 2'b00;
  localparam logic [1:0] SNP_HITM  = 2'b01;
  localparam logic [1:0] SNP_NOHIT = 2'b10;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [1:0]       line_q [NUM_LINES];

  logic [1:0] cur_st;
  logic [1:0] nxt_st;
  logic [2:0] bus_c;
  logic [1:0] snp_c;
  logic       err_c;
  logic       accept;
  logic       do_op;
  logic       clear_done;

  assign cur_st     = line_q[op_idx];
  assign accept     = op_valid & op_ready;
  assign do_op      = accept && (state_q == IDLE) && (op_code != OP_CLEAR);
  assign clear_done = (state_q == SWEEP) && (sweep_q == LAST_IDX);

  // MESI next-state, bus request and snoop reply for the addressed line
  always_comb begin
    nxt_st = cur_st;
    bus_c  = BUS_NONE;
    snp_c  = SNP_NOHIT;
    err_c  = 1'b0;
    case (op_code)
      OP_PR_RD: begin
        if (cur_st == ST_I) begin
          bus_c  = BUS_READ;
          nxt_st = ((snoop_in == SNP_HIT) || (snoop_in == SNP_HITM)) ? ST_S : ST_E;
        end
      end
      OP_PR_WR: begin
        nxt_st = ST_M;
        if (cur_st == ST_I)      bus_c = BUS_RWIM;
        else if (cur_st == ST_S) bus_c = BUS_INV;
      end
      OP_SN_RD: begin
        if (cur_st == ST_M) begin
          nxt_st = ST_S;
          snp_c  = SNP_HITM;
          bus_c  = BUS_WRITE;
        end else if (cur_st != ST_I) begin
          nxt_st = ST_S;
          snp_c  = SNP_HIT;
        end
      end
      OP_SN_WR: begin
        err_c = (cur_st != ST_I);
      end
      OP_SN_RWIM: begin
        nxt_st = ST_I;
        if (cur_st == ST_M) begin
          snp_c = SNP_HITM;
          bus_c = BUS_WRITE;
        end else if (cur_st != ST_I) begin
          snp_c = SNP_HIT;
        end
      end
      OP_SN_INV: begin
        if (cur_st == ST_S) begin
          nxt_st = ST_I;
          snp_c  = SNP_HIT;
        end else if (cur_st != ST_I) begin
          err_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sweep controller next state: CLEAR starts a walk over every line index
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      IDLE: begin
        if (accept && (op_code == OP_CLEAR)) begin
          state_d = SWEEP;
          sweep_d = '0;
        end
      end
      SWEEP: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line array, sweep state and registered response outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sweep_q   <= '0;
      for (int i = 0; i < NUM_LINES; i++) line_q[i] <= ST_I;
      op_ready  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_old   <= ST_I;
      rsp_new   <= ST_I;
      bus_op    <= BUS_NONE;
      snoop_out <= SNP_NOHIT;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      rsp_valid <= 1'b0;
      if (state_q == SWEEP) begin
        line_q[sweep_q] <= ST_I;
        if (clear_done) begin
          op_ready  <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_old   <= ST_I;
          rsp_new   <= ST_I;
          bus_op    <= BUS_NONE;
          snoop_out <= SNP_NOHIT;
          proto_err <= 1'b0;
        end
      end else if (accept) begin
        if (op_code == OP_CLEAR) begin
          op_ready <= 1'b0;
        end else begin
          line_q[op_idx] <= nxt_st;
          rsp_valid      <= 1'b1;
          rsp_old        <= cur_st;
          rsp_new        <= nxt_st;
          bus_op         <= bus_c;
          snoop_out      <= snp_c;
          proto_err      <= err_c;
        end
      end
    end
  end

`ifdef MESI_STATS_EN
  logic is_pr;
  logic hit_c;
  logic miss_c;

  // Processor ops count a hit when the line is valid, a miss when it is I
  always_comb begin
    is_pr  = (op_code == OP_PR_RD) || (op_code == OP_PR_WR);
    hit_c  = do_op && is_pr && (cur_st != ST_I);
    miss_c = do_op && is_pr && (cur_st == ST_I);
  end

  // Saturating hit/miss counters, cleared by reset and by CLEAR completion
  always_ff @(posedge clk) begin
    if (!reset || clear_done) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_c && (hit_cnt != '1))   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_c && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_mesi_line_array.sv
// tb_mesi_line_array: directed vector table plus hand-written CLEAR and
// reset-during-sweep sequences for mesi_line_array (counters narrowed to 4 bits
// so saturation is reachable quickly).
module tb_mesi_line_array;

  localparam int unsigned NL    = 16;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [IW-1:0] op_idx;
  logic [1:0]    snoop_in;
  logic          rsp_valid;
  logic [1:0]    rsp_old;
  logic [1:0]    rsp_new;
  logic [2:0]    bus_op;
  logic [1:0]    snoop_out;
  logic          proto_err;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mesi_line_array #(.NUM_LINES(NL), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_idx(op_idx), .snoop_in(snoop_in),
    .rsp_valid(rsp_valid), .rsp_old(rsp_old), .rsp_new(rsp_new),
    .bus_op(bus_op), .snoop_out(snoop_out), .proto_err(proto_err),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] idx;
    logic [1:0] sin;
    logic [1:0] old_s;
    logic [1:0] new_s;
    logic [2:0] bus;
    logic [1:0] sout;
    logic       err;
    int         hit;
    int         miss;
  } vec_t;

  vec_t vecs [24];

  function automatic int cexp(input int v);
`ifdef MESI_STATS_EN
    return (v > CMAX) ? CMAX : v;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input int idx, input logic [1:0] sin);
    op_valid = 1'b1;
    op_code  = op;
    op_idx   = IW'(idx);
    snoop_in = sin;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    int low;
    int stray;
    int nrdy;
    // op, idx, snoop_in, old, new, bus, snoop_out, err, hit, miss
    vecs[0]  = '{3'd0, 4'd3, 2'b10, 2'd0, 2'd2, 3'd1, 2'b10, 1'b0, 0, 1};
    vecs[1]  = '{3'd0, 4'd3, 2'b10, 2'd2, 2'd2, 3'd0, 2'b10, 1'b0, 1, 1};
    vecs[2]  = '{3'd0, 4'd5, 2'b01, 2'd0, 2'd1, 3'd1, 2'b10, 1'b0, 1, 2};
    vecs[3]  = '{3'd1, 4'd5, 2'b10, 2'd1, 2'd3, 3'd3, 2'b10, 1'b0, 2, 2};
    vecs[4]  = '{3'd2, 4'd5, 2'b10, 2'd3, 2'd1, 3'd2, 2'b01, 1'b0, 2, 2};
    vecs[5]  = '{3'd1, 4'd7, 2'b10, 2'd0, 2'd3, 3'd4, 2'b10, 1'b0, 2, 3};
    vecs[6]  = '{3'd4, 4'd7, 2'b10, 2'd3, 2'd0, 3'd2, 2'b01, 1'b0, 2, 3};
    vecs[7]  = '{3'd5, 4'd7, 2'b10, 2'd0, 2'd0, 3'd0, 2'b10, 1'b0, 2, 3};
    vecs[8]  = '{3'd0, 4'd2, 2'b10, 2'd0, 2'd2, 3'd1, 2'b10, 1'b0, 2, 4};
    vecs[9]  = '{3'd5, 4'd2, 2'b10, 2'd2, 2'd2, 3'd0, 2'b10, 1'b1, 2, 4};
    vecs[10] = '{3'd3, 4'd2, 2'b10, 2'd2, 2'd2, 3'd0, 2'b10, 1'b1, 2, 4};
    vecs[11] = '{3'd2, 4'd2, 2'b10, 2'd2, 2'd1, 3'd0, 2'b00, 1'b0, 2, 4};
    vecs[12] = '{3'd5, 4'd2, 2'b10, 2'd1, 2'd0, 3'd0, 2'b00, 1'b0, 2, 4};
    vecs[13] = '{3'd0, 4'd2, 2'b00, 2'd0, 2'd1, 3'd1, 2'b10, 1'b0, 2, 5};
    vecs[14] = '{3'd0, 4'd4, 2'b11, 2'd0, 2'd2, 3'd1, 2'b10, 1'b0, 2, 6};
    vecs[15] = '{3'd1, 4'd4, 2'b10, 2'd2, 2'd3, 3'd0, 2'b10, 1'b0, 3, 6};
    vecs[16] = '{3'd1, 4'd4, 2'b10, 2'd3, 2'd3, 3'd0, 2'b10, 1'b0, 4, 6};
    vecs[17] = '{3'd7, 4'd4, 2'b10, 2'd3, 2'd3, 3'd0, 2'b10, 1'b0, 4, 6};
    vecs[18] = '{3'd4, 4'd5, 2'b10, 2'd1, 2'd0, 3'd0, 2'b00, 1'b0, 4, 6};
    vecs[19] = '{3'd4, 4'd5, 2'b10, 2'd0, 2'd0, 3'd0, 2'b10, 1'b0, 4, 6};
    vecs[20] = '{3'd2, 4'd3, 2'b10, 2'd2, 2'd1, 3'd0, 2'b00, 1'b0, 4, 6};
    vecs[21] = '{3'd3, 4'd6, 2'b10, 2'd0, 2'd0, 3'd0, 2'b10, 1'b0, 4, 6};
    vecs[22] = '{3'd3, 4'd4, 2'b10, 2'd3, 2'd3, 3'd0, 2'b10, 1'b1, 4, 6};
    vecs[23] = '{3'd0, 4'd3, 2'b10, 2'd1, 2'd1, 3'd0, 2'b10, 1'b0, 5, 6};

    reset    = 1'b0;
    op_valid = 1'b0;
    op_code  = 3'd7;
    op_idx   = '0;
    snoop_in = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    check("reset_op_ready", int'(op_ready), 1);
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_old", int'(rsp_old), 0);
    check("reset_rsp_new", int'(rsp_new), 0);
    check("reset_bus_op", int'(bus_op), 0);
    check("reset_snoop_out", int'(snoop_out), 2);
    check("reset_proto_err", int'(proto_err), 0);
    check("reset_hit_cnt", int'(hit_cnt), 0);
    check("reset_miss_cnt", int'(miss_cnt), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table of operations
    for (int i = 0; i < 24; i++) begin
      op_valid = 1'b1;
      op_code  = vecs[i].op;
      op_idx   = vecs[i].idx;
      snoop_in = vecs[i].sin;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rsp_valid", i), int'(rsp_valid), 1);
      check($sformatf("v%0d_rsp_old", i), int'(rsp_old), int'(vecs[i].old_s));
      check($sformatf("v%0d_rsp_new", i), int'(rsp_new), int'(vecs[i].new_s));
      check($sformatf("v%0d_bus_op", i), int'(bus_op), int'(vecs[i].bus));
      check($sformatf("v%0d_snoop_out", i), int'(snoop_out), int'(vecs[i].sout));
      check($sformatf("v%0d_proto_err", i), int'(proto_err), int'(vecs[i].err));
      check($sformatf("v%0d_hit_cnt", i), int'(hit_cnt), cexp(vecs[i].hit));
      check($sformatf("v%0d_miss_cnt", i), int'(miss_cnt), cexp(vecs[i].miss));
    end
    op_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rsp_valid", int'(rsp_valid), 0);
    check("idle_rsp_new_held", int'(rsp_new), 1);

    // Twelve more misses push miss_cnt past its 4-bit ceiling
    for (int k = 0; k < 12; k++) begin
      drive(3'd0, 8, 2'b10);
      drive(3'd4, 8, 2'b10);
    end
    check("sat_miss_cnt", int'(miss_cnt), cexp(18));
    check("sat_hit_cnt", int'(hit_cnt), cexp(5));

    // Fill all lines, then CLEAR with an op held valid while not ready
    for (int i = 0; i < NL; i++) drive(3'd1, i, 2'b10);
    op_valid = 1'b1;
    op_code  = 3'd6;
    @(posedge clk);
    #1;
    check("clear_accept_ready", int'(op_ready), 0);
    check("clear_accept_rsp", int'(rsp_valid), 0);
    op_code = 3'd1;
    op_idx  = '0;
    low   = 1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (op_ready) break;
      low++;
      if (rsp_valid) stray++;
    end
    op_valid = 1'b0;
    check("clear_low_cycles", low, 16);
    check("clear_stray_rsp", stray, 0);
    check("clear_done_rsp_valid", int'(rsp_valid), 1);
    check("clear_done_old", int'(rsp_old), 0);
    check("clear_done_new", int'(rsp_new), 0);
    check("clear_done_bus", int'(bus_op), 0);
    check("clear_hit_cnt", int'(hit_cnt), 0);
    check("clear_miss_cnt", int'(miss_cnt), 0);
    @(posedge clk);
    #1;
    check("clear_pulse_1cyc", int'(rsp_valid), 0);
    for (int i = 0; i < NL; i++) begin
      drive(3'd0, i, 2'b10);
      check($sformatf("post_clear_old_%0d", i), int'(rsp_old), 0);
      check($sformatf("post_clear_new_%0d", i), int'(rsp_new), 2);
      check($sformatf("post_clear_bus_%0d", i), int'(bus_op), 1);
    end
    check("post_clear_miss_cnt", int'(miss_cnt), cexp(16));
    check("post_clear_hit_cnt", int'(hit_cnt), 0);

    // Reset in the middle of a sweep aborts it without a response
    drive(3'd6, 0, 2'b10);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_sweep_ready", int'(op_ready), 1);
    check("rst_sweep_rsp", int'(rsp_valid), 0);
    check("rst_sweep_snoop_out", int'(snoop_out), 2);
    check("rst_sweep_miss_cnt", int'(miss_cnt), 0);
    reset = 1'b1;
    stray = 0;
    nrdy  = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) stray++;
      if (!op_ready) nrdy++;
    end
    check("rst_sweep_no_pulse", stray, 0);
    check("rst_sweep_ready_held", nrdy, 0);
    drive(3'd0, 12, 2'b10);
    check("rst_sweep_line_old", int'(rsp_old), 0);
    check("rst_sweep_line_new", int'(rsp_new), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
